router_output_scheduler: RTL

//  Per-output-port scheduler for the 16x16 crossbar router; one instance per output port.

---
 rtl/router_output_scheduler.sv | 131 +++++++++++++
 1 files changed

// File: rtl/router_output_scheduler.sv
// Per-output-port scheduler for the crossbar router: round-robin arbitration among
// requesting inputs, grant held for a whole frame, watchdog reclaims a stalled owner.
module router_output_scheduler #(
  parameter int N_IN    = 16,
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_IN-1:0]  req,
  input  logic [N_IN-1:0]  frame_n,
  output logic [N_IN-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld,
  output logic             busy_n,
  output logic             timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_DRAIN} state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nx;
  logic [CNT_W-1:0] wd_cnt, wd_cnt_nx;
  logic             frame_q, frame_q_nx;
  logic [N_IN-1:0]  grant_nx;
  logic [IDX_W-1:0] grant_idx_nx;
  logic             grant_vld_nx, busy_n_nx, timeout_err_nx;

  logic             arb_found;
  logic [IDX_W-1:0] arb_idx, cand;
  logic             owner_frame, owner_req, rel_norm, rel_tmo;

  // Round-robin search starting just after the last released owner.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_IN; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % N_IN);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign owner_frame = frame_n[grant_idx];
  assign owner_req   = req[grant_idx];
  // Frame ended, or owner gave up before its frame started.
  assign rel_norm    = (!frame_q && owner_frame) || (!owner_req && owner_frame && frame_q);
  assign rel_tmo     = (wd_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nx       = state;
    rr_ptr_nx      = rr_ptr;
    wd_cnt_nx      = wd_cnt;
    frame_q_nx     = frame_q;
    grant_nx       = grant;
    grant_idx_nx   = grant_idx;
    grant_vld_nx   = grant_vld;
    busy_n_nx      = busy_n;
    timeout_err_nx = 1'b0;
    case (state)
      S_IDLE: begin
        busy_n_nx = 1'b1;
        if (arb_found) begin
          grant_nx     = {{(N_IN-1){1'b0}}, 1'b1} << arb_idx;
          grant_idx_nx = arb_idx;
          grant_vld_nx = 1'b1;
          busy_n_nx    = 1'b0;
          state_nx     = S_OWN;
        end
      end
      S_OWN: begin
        wd_cnt_nx  = wd_cnt + CNT_W'(1);
        frame_q_nx = owner_frame;
        if (rel_norm || rel_tmo) begin
          grant_nx       = '0;
          grant_vld_nx   = 1'b0;
          busy_n_nx      = 1'b0;
          wd_cnt_nx      = '0;
          frame_q_nx     = 1'b1;
          rr_ptr_nx      = grant_idx;
          timeout_err_nx = !rel_norm;
          state_nx       = S_DRAIN;
        end
      end
      S_DRAIN: begin
        grant_nx     = '0;
        grant_vld_nx = 1'b0;
        busy_n_nx    = 1'b0;
        if (arb_found) begin
          grant_nx     = {{(N_IN-1){1'b0}}, 1'b1} << arb_idx;
          grant_idx_nx = arb_idx;
          grant_vld_nx = 1'b1;
          state_nx     = S_OWN;
        end else begin
          busy_n_nx = 1'b1;
          state_nx  = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      rr_ptr      <= IDX_W'(N_IN - 1);
      wd_cnt      <= '0;
      frame_q     <= 1'b1;
      grant       <= '0;
      grant_idx   <= '0;
      grant_vld   <= 1'b0;
      busy_n      <= 1'b1;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      rr_ptr      <= rr_ptr_nx;
      wd_cnt      <= wd_cnt_nx;
      frame_q     <= frame_q_nx;
      grant       <= grant_nx;
      grant_idx   <= grant_idx_nx;
      grant_vld   <= grant_vld_nx;
      busy_n      <= busy_n_nx;
      timeout_err <= timeout_err_nx;
    end
  end

endmodule
